vga_window_checker: RTL and testbench

VGA_WINDOW_CHECKER -- requirements
Module: vga_window_checker

---
 rtl/vga_window_checker.sv | 203 ++++++++++++++++++++
 tb/tb_vga_window_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_window_checker.sv
// vga_window_checker
// Compares received VGA pixels inside a rectangular window against an
// expected-pixel stream, reports per-channel mismatches, counts them and
// aborts the frame check once the count passes MAX_MISMATCHES.
// Optional feature: define VGA_CHECKER_CRC_EN to build a CRC-16-CCITT
// signature of the compared pixels on Frame_crc; otherwise Frame_crc is 0.
`timescale 1ns/1ps
module vga_window_checker #(
  parameter int H_LEFT         = 160,
  parameter int H_RIGHT        = 480,
  parameter int V_TOP          = 120,
  parameter int V_BOTTOM       = 360,
  parameter int CH_COUNT       = 3,
  parameter int CH_WIDTH       = 10,
  parameter int EXP_WIDTH      = 8,
  parameter int PIXEL_DIV      = 2,
  parameter int MAX_MISMATCHES = 10
) (
  input  logic                          Clock_50,
  input  logic                          Reset,
  input  logic                          Enable,
  input  logic                          VSync_n,
  input  logic [9:0]                    Pixel_X,
  input  logic [9:0]                    Pixel_Y,
  input  logic [CH_COUNT*CH_WIDTH-1:0]  Pixel_data,
  input  logic                          Expected_valid,
  input  logic [CH_COUNT*EXP_WIDTH-1:0] Expected_data,
  output logic                          Expected_ready,
  output logic                          Mismatch_valid,
  output logic [CH_COUNT-1:0]           Mismatch_mask,
  output logic [9:0]                    Mismatch_X,
  output logic [9:0]                    Mismatch_Y,
  output logic [15:0]                   Mismatch_count,
  output logic                          Underflow,
  output logic                          Frame_done,
  output logic                          Abort,
  output logic [15:0]                   Frame_crc
);

  localparam int PH_W = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
  localparam int PAD  = CH_WIDTH - EXP_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_SYNC, S_ACTIVE, S_DONE, S_ABORT
  } state_t;

  state_t               r_state, w_next;
  logic [PH_W-1:0]      r_phase;
  logic [9:0]           r_pos_x, r_pos_y;
  logic                 r_mm_valid;
  logic [CH_COUNT-1:0]  r_mm_mask;
  logic [9:0]           r_mm_x, r_mm_y;
  logic [15:0]          r_count;
  logic                 r_underflow;

  logic                 w_run, w_strobe, w_in_win, w_compare, w_check;
  logic                 w_arm, w_abort;
  logic [CH_COUNT-1:0]  w_mask;
  logic [16:0]          w_count_sum;
  logic [15:0]          w_count_next;

  // Phase runs only while a frame is being scanned; the last phase is the pixel strobe.
  assign w_run     = (r_state == S_ACTIVE) && VSync_n;
  assign w_strobe  = w_run && (r_phase == PH_W'(PIXEL_DIV - 1));
  // Window test uses the position captured at the previous strobe (one-pixel lag).
  assign w_in_win  = (r_pos_y >= 10'(V_TOP))  && (r_pos_y < 10'(V_BOTTOM)) &&
                     (r_pos_x >= 10'(H_LEFT)) && (r_pos_x < 10'(H_RIGHT));
  assign w_compare = w_strobe && w_in_win;
  assign w_check   = w_compare && Expected_valid;
  assign w_abort   = w_check && (|w_mask) && (32'(w_count_next) > MAX_MISMATCHES);
  assign w_arm     = (r_state == S_ARMED) && (w_next == S_SYNC);

  // Per-channel compare against the expected value left-justified into CH_WIDTH bits.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_mask = '0;
    for (int i = 0; i < CH_COUNT; i++) begin
      w_mask[i] = Pixel_data[i*CH_WIDTH +: CH_WIDTH] !=
                  (CH_WIDTH'(Expected_data[i*EXP_WIDTH +: EXP_WIDTH]) << PAD);
    end
  end

  // Saturating mismatch count after adding this compare's failing channels.
  always_comb begin
    // NOTE: blocking '=' here because the sum is built up step by step within one evaluation.
    w_count_sum = {1'b0, r_count};
    for (int i = 0; i < CH_COUNT; i++) begin
      w_count_sum = w_count_sum + 17'(w_mask[i]);
    end
    w_count_next = w_count_sum[16] ? 16'hFFFF : w_count_sum[15:0];
  end

  // Next-state logic; Enable low always returns to idle, abort beats end-of-frame.
  always_comb begin
    w_next = r_state;
    if (!Enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_next = S_ARMED;
        S_ARMED:  if (!VSync_n) w_next = S_SYNC;
        S_SYNC:   if (VSync_n)  w_next = S_ACTIVE;
        S_ACTIVE: begin
          if (w_abort)       w_next = S_ABORT;
          else if (!VSync_n) w_next = S_DONE;
        end
        default:  w_next = r_state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    // NOTE: non-blocking '<=' for all clocked state so every register samples pre-edge values.
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Pixel phase counter and captured pixel position.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      r_phase <= '0;
      r_pos_x <= '0;
      r_pos_y <= '0;
    end else begin
      if (!w_run || w_strobe) r_phase <= '0;
      else                    r_phase <= r_phase + 1'b1;
      if (!VSync_n) begin
        r_pos_x <= '0;
        r_pos_y <= '0;
      end else if (w_strobe) begin
        r_pos_x <= Pixel_X;
        r_pos_y <= Pixel_Y;
      end
    end
  end

  // Mismatch report, one cycle after the failing compare.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      r_mm_valid <= 1'b0;
      r_mm_mask  <= '0;
      r_mm_x     <= '0;
      r_mm_y     <= '0;
    end else begin
      r_mm_valid <= w_check && (|w_mask);
      if (w_check && (|w_mask)) begin
        r_mm_mask <= w_mask;
        r_mm_x    <= r_pos_x;
        r_mm_y    <= r_pos_y;
      end
    end
  end

  // Frame statistics: cleared when the checker arms onto a frame.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else if (w_arm) begin
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_check)                      r_count     <= w_count_next;
      if (w_compare && !Expected_valid) r_underflow <= 1'b1;
    end
  end

`ifdef VGA_CHECKER_CRC_EN
  logic [15:0] r_crc, w_crc_next;

  // CRC-16-CCITT (0x1021), MSB first over the whole received pixel word.
  always_comb begin
    w_crc_next = r_crc;
    for (int i = CH_COUNT*CH_WIDTH-1; i >= 0; i--) begin
      w_crc_next = {w_crc_next[14:0], 1'b0} ^
                   ((w_crc_next[15] ^ Pixel_data[i]) ? 16'h1021 : 16'h0000);
    end
  end

  // Signature register; seeded at arm, advanced on every compare including underflows.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset)          r_crc <= '0;
    else if (w_arm)     r_crc <= 16'hFFFF;
    else if (w_compare) r_crc <= w_crc_next;
  end

  assign Frame_crc = r_crc;
`else
  assign Frame_crc = 16'h0000;
`endif

  assign Expected_ready = w_compare;
  assign Mismatch_valid = r_mm_valid;
  assign Mismatch_mask  = r_mm_mask;
  assign Mismatch_X     = r_mm_x;
  assign Mismatch_Y     = r_mm_y;
  assign Mismatch_count = r_count;
  assign Underflow      = r_underflow;
  assign Frame_done     = (r_state == S_DONE);
  assign Abort          = (r_state == S_ABORT);

endmodule

// File: tb/tb_vga_window_checker.sv
// tb_vga_window_checker
// Drives small scanned frames through vga_window_checker with a reduced
// window. A pixel-level reference model predicts compares, mismatch reports,
// counts, underflow and CRC; a monitor pops predicted reports as the DUT
// emits them. Honours VGA_CHECKER_CRC_EN like the design.
`timescale 1ns/1ps
module tb_vga_window_checker;

  localparam int H_LEFT = 5, H_RIGHT = 13, V_TOP = 3, V_BOTTOM = 7;
  localparam int CH_COUNT = 3, CH_WIDTH = 10, EXP_WIDTH = 8;
  localparam int PIXEL_DIV = 2, MAX_MM = 10;
  localparam int H_TOTAL = 20, V_TOTAL = 10, VS_SLOTS = 4;
  localparam int DW = CH_COUNT * CH_WIDTH;
  localparam int EW = CH_COUNT * EXP_WIDTH;
  localparam int PAD_MUL = 1 << (CH_WIDTH - EXP_WIDTH);
`ifdef VGA_CHECKER_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, vsync_n, ev;
  logic [9:0] px, py;
  logic [DW-1:0] pdata;
  logic [EW-1:0] edata;
  logic eready, mvalid, uf, done, abort_o;
  logic [CH_COUNT-1:0] mmask;
  logic [9:0] mx, my;
  logic [15:0] mcount, crc;

  always #5 clk = ~clk;

  vga_window_checker #(
    .H_LEFT(H_LEFT), .H_RIGHT(H_RIGHT), .V_TOP(V_TOP), .V_BOTTOM(V_BOTTOM),
    .CH_COUNT(CH_COUNT), .CH_WIDTH(CH_WIDTH), .EXP_WIDTH(EXP_WIDTH),
    .PIXEL_DIV(PIXEL_DIV), .MAX_MISMATCHES(MAX_MM)
  ) dut (
    .Clock_50(clk), .Reset(rst), .Enable(en), .VSync_n(vsync_n),
    .Pixel_X(px), .Pixel_Y(py), .Pixel_data(pdata),
    .Expected_valid(ev), .Expected_data(edata), .Expected_ready(eready),
    .Mismatch_valid(mvalid), .Mismatch_mask(mmask),
    .Mismatch_X(mx), .Mismatch_Y(my), .Mismatch_count(mcount),
    .Underflow(uf), .Frame_done(done), .Abort(abort_o), .Frame_crc(crc)
  );

  typedef struct packed {
    logic [CH_COUNT-1:0] mask;
    logic [9:0]          x;
    logic [9:0]          y;
  } mm_ev_t;

  mm_ev_t mm_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int ready_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
  endtask

  // Monitor: count stream pops and match every mismatch report to the prediction queue.
  always @(negedge clk) begin
    if (eready === 1'b1) ready_seen++;
    if (mvalid === 1'b1) begin
      if (mm_q.size() == 0) begin
        n_checks++;
        $display("FAIL mm_unexpected: mask=%b x=%0d y=%0d, no report predicted", mmask, mx, my);
      end else begin
        mm_ev_t e;
        e = mm_q.pop_front();
        check("mm_mask", 64'(mmask), 64'(e.mask));
        check("mm_x",    64'(mx),    64'(e.x));
        check("mm_y",    64'(my),    64'(e.y));
      end
    end
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [DW-1:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  task automatic drive_slot(input logic vs, input int x, input int y,
                            input logic [DW-1:0] d, input logic [EW-1:0] e, input logic v);
    vsync_n = vs; px = 10'(x); py = 10'(y); pdata = d; edata = e; ev = v;
    repeat (PIXEL_DIV) @(posedge clk);
    #1;
  endtask

  // mode: 0 clean, 1 one bad pixel at (ex,ey) on channels emask, 2 all channels bad,
  //       3 expected stream empty at first compare, 4 random data/errors/underflows
  task automatic run_frame(input string tag, input int mode, input int ex, input int ey,
                           input logic [CH_COUNT-1:0] emask, input bit rearm, input int rst_slot);
    int m_count, m_cmps, prev_x, prev_y, cx, cy, base, nmm, dc, ec;
    bit m_uf, m_abort, m_live, first_cmp, cmp, bad;
    logic [15:0] m_crc;
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    logic v;
    logic [7:0] cv;
    logic [CH_COUNT-1:0] mask;
    m_count = 0; m_cmps = 0; m_uf = 0; m_abort = 0; m_live = 1; first_cmp = 1;
    m_crc = CRC_ON ? 16'hFFFF : 16'h0000;
    prev_x = 0; prev_y = 0;
    base = ready_seen;
    if (rearm) begin
      en = 1'b0; drive_slot(1'b1, 0, 0, '0, '0, 1'b0);
      en = 1'b1; drive_slot(1'b1, 0, 0, '0, '0, 1'b0);
    end
    for (int k = 0; k < VS_SLOTS; k++) drive_slot(1'b0, 0, 0, DW'($urandom), EW'($urandom), 1'b1);
    for (int k = 0; k < H_TOTAL * V_TOTAL; k++) begin
      cx = k % H_TOTAL;
      cy = k / H_TOTAL;
      if (k == rst_slot) begin
        rst = 1'b1; m_live = 0; m_count = 0; m_uf = 0; m_abort = 0; m_crc = 16'h0000;
        #1;
        check({tag, "_reset_zero"},
              64'({eready, mvalid, mmask, mx, my, mcount, uf, done, abort_o, crc}), 64'(0));
      end
      // Each slot carries the pixel belonging to the previous slot's position.
      cmp = (k > 0) && m_live && !m_abort &&
            prev_x >= H_LEFT && prev_x < H_RIGHT && prev_y >= V_TOP && prev_y < V_BOTTOM;
      if (cmp) begin
        for (int c = 0; c < CH_COUNT; c++) begin
          cv = (mode == 4) ? 8'($urandom) : 8'(prev_x * 7 + prev_y * 13 + c * 29 + 1);
          d[(CH_COUNT-1-c)*CH_WIDTH +: CH_WIDTH]   = CH_WIDTH'(int'(cv) * PAD_MUL);
          e[(CH_COUNT-1-c)*EXP_WIDTH +: EXP_WIDTH] = cv;
          bad = (mode == 2) ||
                (mode == 1 && prev_x == ex && prev_y == ey && emask[CH_COUNT-1-c]) ||
                (mode == 4 && $urandom_range(0, 19) == 0);
          if (bad) begin
            if ($urandom_range(0, 1) == 1)
              e[(CH_COUNT-1-c)*EXP_WIDTH +: EXP_WIDTH] = cv ^ 8'($urandom_range(1, 255));
            else
              d[(CH_COUNT-1-c)*CH_WIDTH +: CH_WIDTH] =
                CH_WIDTH'(int'(cv) * PAD_MUL + int'($urandom_range(1, PAD_MUL - 1)));
          end
        end
        v = !((mode == 3 && first_cmp) || (mode == 4 && $urandom_range(0, 15) == 0));
        m_cmps++;
        first_cmp = 0;
        if (CRC_ON) m_crc = crc_step(m_crc, d);
        if (!v) begin
          m_uf = 1;
        end else begin
          mask = '0; nmm = 0;
          for (int c = 0; c < CH_COUNT; c++) begin
            dc = int'(d[(CH_COUNT-1-c)*CH_WIDTH +: CH_WIDTH]);
            ec = int'(e[(CH_COUNT-1-c)*EXP_WIDTH +: EXP_WIDTH]);
            if (dc != ec * PAD_MUL) begin
              mask[CH_COUNT-1-c] = 1'b1;
              nmm++;
            end
          end
          if (nmm > 0) begin
            m_count = m_count + nmm;
            if (m_count > 65535) m_count = 65535;
            mm_q.push_back('{mask: mask, x: 10'(prev_x), y: 10'(prev_y)});
            if (m_count > MAX_MM) m_abort = 1;
          end
        end
      end else begin
        d = DW'($urandom); e = EW'($urandom); v = 1'($urandom);
      end
      drive_slot(1'b1, cx, cy, d, e, v);
      if (k == rst_slot) rst = 1'b0;
      prev_x = cx;
      prev_y = cy;
    end
    if (rst_slot < 0) drive_slot(1'b0, 0, 0, DW'($urandom), EW'($urandom), 1'b1);
    @(negedge clk);
    check({tag, "_done"},   64'(done),    64'((rst_slot < 0) && !m_abort));
    check({tag, "_abort"},  64'(abort_o), 64'(m_abort));
    check({tag, "_count"},  64'(mcount),  64'(m_count));
    check({tag, "_uflow"},  64'(uf),      64'(m_uf));
    check({tag, "_crc"},    64'(crc),     64'(m_crc));
    check({tag, "_ready_pulses"}, 64'(ready_seen - base), 64'(m_cmps));
    check({tag, "_reports_left"}, 64'(mm_q.size()), 64'(0));
    mm_q.delete();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; vsync_n = 1'b1; px = '0; py = '0;
    pdata = '0; edata = '0; ev = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({eready, mvalid, mmask, mx, my, mcount, uf, done, abort_o, crc}), 64'(0));
    rst = 1'b0;
    drive_slot(1'b1, 0, 0, '0, '0, 1'b0);
    check("idle_no_done", 64'({done, abort_o}), 64'(0));

    run_frame("clean",     0, 0, 0, 3'b000, 1'b1, -1);
    run_frame("single",    1, 7, 4, 3'b100, 1'b1, -1);
    run_frame("abort",     2, 0, 0, 3'b000, 1'b1, -1);
    run_frame("uflow",     3, 0, 0, 3'b000, 1'b1, -1);
    run_frame("midreset",  0, 0, 0, 3'b000, 1'b1, 90);
    run_frame("after_rst", 0, 0, 0, 3'b000, 1'b0, -1);
    run_frame("clean2",    0, 0, 0, 3'b000, 1'b1, -1);
    for (int f = 0; f < 3; f++) run_frame($sformatf("rand%0d", f), 4, 0, 0, 3'b000, 1'b1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
